// File: rtl/dds_freq_meter_if.sv
// rtl/dds_freq_meter_if.sv - sample stream in, measurement results out for dds_freq_meter
interface dds_freq_meter_if #(
   parameter int INC_WIDTH    = 32,
   parameter int SAMPLE_WIDTH = 14,
   parameter int CNT_WIDTH    = 32
);
   logic                           enable;
   logic                           valid;
   logic signed [SAMPLE_WIDTH-1:0] sample;
   logic [INC_WIDTH-1:0]           incremento;
   logic [CNT_WIDTH-1:0]           periodo;
   logic                           result_valid;
   logic                           busy;
   logic                           timeout;
   logic [2:0]                     leds;

   modport master (
      output enable, valid, sample,
      input  incremento, periodo, result_valid, busy, timeout, leds
   );

   modport slave (
      input  enable, valid, sample,
      output incremento, periodo, result_valid, busy, timeout, leds
   );
endinterface

// File: rtl/dds_freq_meter.sv
// rtl/dds_freq_meter.sv - measures a signed sine stream's period and recovers its DDS tuning word
module dds_freq_meter #(
   parameter int INC_WIDTH    = 32,
   parameter int SAMPLE_WIDTH = 14,
   parameter int LOG2_PERIODS = 4,
   parameter int CNT_WIDTH    = 32,
   parameter int HYST         = 64
) (
   input logic              clk,
   input logic              rst,
   dds_freq_meter_if.slave  bus
);
   localparam int QW = INC_WIDTH + LOG2_PERIODS + 1;
   localparam int SW = $clog2(QW + 1);
   localparam logic [SW-1:0] LAST_STEP = SW'(QW - 1);
   localparam logic [LOG2_PERIODS-1:0] PER_LAST = '1;
   localparam logic signed [SAMPLE_WIDTH-1:0] NEG_HYST = SAMPLE_WIDTH'(-HYST);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC    = 3'd1,
      MEASURE = 3'd2,
      DIVIDE  = 3'd3,
      DONE    = 3'd4,
      TIMEOUT = 3'd5
   } state_t;

   state_t                  state;
   logic                    armed;
   logic [CNT_WIDTH-1:0]    cnt;
   logic [CNT_WIDTH-1:0]    n_lat;
   logic [LOG2_PERIODS-1:0] per;
   logic [CNT_WIDTH-1:0]    rem;
   logic [QW-1:0]           quot;
   logic [SW-1:0]           step;

   logic                    below;
   logic                    xing;
   logic                    rem_ge;
   logic                    sat;
   logic [CNT_WIDTH:0]      rem_shift;

   // The dividend 2**(QW-1) has only its top bit set, so it enters on the first step only.
   always_comb begin
      below     = bus.sample < NEG_HYST;
      xing      = bus.valid && armed && !bus.sample[SAMPLE_WIDTH-1];
      rem_shift = {rem, (step == '0)};
      rem_ge    = rem_shift >= {1'b0, n_lat};
      sat       = |quot[QW-1:INC_WIDTH];
   end

   assign bus.leds = state;
   assign bus.busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         armed            <= 1'b0;
         cnt              <= '0;
         n_lat            <= '0;
         per              <= '0;
         rem              <= '0;
         quot             <= '0;
         step             <= '0;
         bus.incremento   <= '0;
         bus.periodo      <= '0;
         bus.result_valid <= 1'b0;
         bus.timeout      <= 1'b0;
      end else begin
         bus.result_valid <= 1'b0;
         if (!bus.enable) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  state <= SYNC;
                  cnt   <= '0;
                  armed <= 1'b0;
               end
               SYNC: begin
                  if (bus.valid) begin
                     if (cnt == '1) begin
                        state <= TIMEOUT;
                     end else if (xing) begin
                        state <= MEASURE;
                        cnt   <= '0;
                        per   <= '0;
                        armed <= 1'b0;
                     end else begin
                        cnt <= cnt + 1'b1;
                        if (below) armed <= 1'b1;
                     end
                  end
               end
               MEASURE: begin
                  if (bus.valid) begin
                     if (cnt == '1) begin
                        state <= TIMEOUT;
                     end else begin
                        cnt <= cnt + 1'b1;
                        if (xing) begin
                           armed <= 1'b0;
                           per   <= per + 1'b1;
                           // N includes the final crossing sample itself.
                           if (per == PER_LAST) begin
                              state <= DIVIDE;
                              n_lat <= cnt + 1'b1;
                              rem   <= '0;
                              quot  <= '0;
                              step  <= '0;
                           end
                        end else if (below) begin
                           armed <= 1'b1;
                        end
                     end
                  end
               end
               DIVIDE: begin
                  rem  <= CNT_WIDTH'(rem_ge ? rem_shift - {1'b0, n_lat} : rem_shift);
                  quot <= {quot[QW-2:0], rem_ge};
                  step <= step + 1'b1;
                  if (step == LAST_STEP) state <= DONE;
               end
               DONE: begin
                  bus.result_valid <= 1'b1;
                  bus.periodo      <= n_lat;
                  bus.timeout      <= 1'b0;
                  bus.incremento   <= sat ? '1 : quot[INC_WIDTH-1:0];
                  state            <= SYNC;
                  cnt              <= '0;
                  armed            <= 1'b0;
               end
               TIMEOUT: begin
                  bus.timeout <= 1'b1;
                  state       <= SYNC;
                  cnt         <= '0;
                  armed       <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_dds_freq_meter.sv
// tb/tb_dds_freq_meter.sv - scoreboard bench for dds_freq_meter (default and 12-bit counter instances)
module tb_dds_freq_meter;
   typedef struct {
      logic [31:0] inc;
      logic [31:0] per;
      int          tol;
      bit          chk_per;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic en_a, en_b, s_valid;
   logic signed [13:0] s_sample;

   int tests_run = 0;
   int failed = 0;
   int rx_a = 0;
   int rx_b = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   always #4 clk = ~clk;

   dds_freq_meter_if bus_a ();
   dds_freq_meter_if #(.CNT_WIDTH(12)) bus_b ();

   assign bus_a.enable = en_a;
   assign bus_a.valid  = s_valid;
   assign bus_a.sample = s_sample;
   assign bus_b.enable = en_b;
   assign bus_b.valid  = s_valid;
   assign bus_b.sample = s_sample;

   dds_freq_meter dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   dds_freq_meter #(.CNT_WIDTH(12)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   // One clock; outputs sampled on the falling edge and matched against the scoreboards.
   task automatic tick();
      exp_t   e;
      longint d;
      @(posedge clk);
      @(negedge clk);
      if (bus_a.result_valid === 1'b1) begin
         tests_run++;
         if (q_a.size() == 0) begin
            failed++;
            $display("FAIL sb_a unexpected result inc=%h per=%0d", bus_a.incremento, bus_a.periodo);
         end else begin
            e = q_a.pop_front();
            d = longint'(bus_a.incremento) - longint'(e.inc);
            if (d > e.tol || d < -e.tol || (e.chk_per && bus_a.periodo !== e.per) || bus_a.timeout !== 1'b0) begin
               failed++;
               $display("FAIL sb_a got inc=%h per=%0d to=%b, want inc=%h(+/-%0h) per=%0d to=0",
                        bus_a.incremento, bus_a.periodo, bus_a.timeout, e.inc, e.tol, e.per);
            end
         end
         rx_a++;
      end
      if (bus_b.result_valid === 1'b1) begin
         tests_run++;
         if (q_b.size() == 0) begin
            failed++;
            $display("FAIL sb_b unexpected result inc=%h per=%0d", bus_b.incremento, bus_b.periodo);
         end else begin
            e = q_b.pop_front();
            if (bus_b.incremento !== e.inc || bus_b.periodo !== e.per[11:0] || bus_b.timeout !== 1'b0) begin
               failed++;
               $display("FAIL sb_b got inc=%h per=%0d to=%b, want inc=%h per=%0d to=0",
                        bus_b.incremento, bus_b.periodo, bus_b.timeout, e.inc, e.per);
            end
         end
         rx_b++;
      end
   endtask

   // mode 0 square, 1 square with +/-30 jitter quarter, 2 DDS sine (period = tuning word), 3 constant
   task automatic drive(input int mode, input int period, input int amp, input bit tog, input bit on_b,
                        input int target, input int stop_leds, input int max_cycles,
                        output bit reached, output int nval);
      int     n = 0;
      int     v;
      bit     ph = 1'b0;
      longint acc = 0;
      reached = 1'b0;
      for (int c = 0; c < max_cycles; c++) begin
         s_valid = tog ? ph : 1'b1;
         ph = ~ph;
         if (s_valid) begin
            case (mode)
               0: v = ((n % period) < period / 2) ? amp : -amp;
               1: v = ((n % period) < period / 4) ? amp :
                      ((n % period) < period / 2) ? int'($urandom_range(60, 0)) - 30 : -amp;
               2: begin
                  v = $rtoi(8000.0 * $sin(6.283185307179586 * real'(acc) / 4294967296.0));
                  acc = (acc + longint'(period)) & 64'hFFFF_FFFF;
               end
               default: v = amp;
            endcase
            s_sample = 14'(v);
            n++;
         end else begin
            s_sample = 14'($urandom);
         end
         tick();
         if ((on_b ? rx_b : rx_a) >= target ||
             (stop_leds >= 0 && int'(on_b ? bus_b.leds : bus_a.leds) == stop_leds)) begin
            reached = 1'b1;
            break;
         end
      end
      s_valid = 1'b0;
      nval = n;
   endtask

   task automatic test_reset();
      bit r;
      int n;
      rst = 1'b1;
      tick();
      tick();
      tests_run++;
      if ({bus_a.leds, bus_a.busy, bus_a.result_valid, bus_a.timeout} !== 6'd0 ||
          bus_a.incremento !== 32'd0 || bus_a.periodo !== 32'd0) begin
         failed++;
         $display("FAIL reset_a leds=%0d busy=%b inc=%h per=%0d, want all 0",
                  bus_a.leds, bus_a.busy, bus_a.incremento, bus_a.periodo);
      end
      tests_run++;
      if ({bus_b.leds, bus_b.busy, bus_b.timeout} !== 5'd0 || bus_b.periodo !== 12'd0) begin
         failed++;
         $display("FAIL reset_b leds=%0d busy=%b per=%0d, want all 0", bus_b.leds, bus_b.busy, bus_b.periodo);
      end
      rst = 1'b0;
      en_a = 1'b1;
      drive(0, 512, 4000, 1'b0, 1'b0, 1000, -1, 800, r, n);
      tests_run++;
      if (bus_a.leds !== 3'd2) begin
         failed++;
         $display("FAIL pre_reset_state leds=%0d, want 2", bus_a.leds);
      end
      rst = 1'b1;
      tick();
      tests_run++;
      if ({bus_a.leds, bus_a.busy, bus_a.result_valid, bus_a.timeout} !== 6'd0 ||
          bus_a.incremento !== 32'd0 || bus_a.periodo !== 32'd0) begin
         failed++;
         $display("FAIL mid_reset leds=%0d busy=%b inc=%h per=%0d, want all 0",
                  bus_a.leds, bus_a.busy, bus_a.incremento, bus_a.periodo);
      end
      rst = 1'b0;
      en_a = 1'b0;
      tick();
   endtask

   task automatic run_a(input int mode, input int period, input bit tog, input int nres, input int max_cycles, input string name);
      bit r;
      int n;
      en_a = 1'b1;
      drive(mode, period, 4000, tog, 1'b0, rx_a + nres, -1, max_cycles, r, n);
      en_a = 1'b0;
      tests_run++;
      if (!r) begin
         failed++;
         $display("FAIL %s no result within %0d cycles, got %0d pending %0d", name, max_cycles, rx_a, q_a.size());
      end
      tick();
      tests_run++;
      if (bus_a.result_valid !== 1'b0) begin
         failed++;
         $display("FAIL %s_pulse valid=%b one cycle after result, want 0", name, bus_a.result_valid);
      end
   endtask

   task automatic test_square();
      q_a.push_back('{inc: 32'h0080_0000, per: 32'd8192, tol: 0, chk_per: 1'b1});
      run_a(0, 512, 1'b0, 1, 9500, "square512");
   endtask

   task automatic test_valid_toggle();
      q_a.push_back('{inc: 32'h0041_8937, per: 32'd16000, tol: 0, chk_per: 1'b1});
      run_a(0, 1000, 1'b1, 1, 36000, "toggle1000");
   endtask

   task automatic test_dds();
      q_a.push_back('{inc: 32'h0076_0A84, per: 32'd0, tol: 32'h4000, chk_per: 1'b0});
      run_a(2, 32'h0076_0A84, 1'b0, 1, 11000, "dds");
   endtask

   task automatic test_back_to_back();
      q_a.push_back('{inc: 32'h0200_0000, per: 32'd2048, tol: 0, chk_per: 1'b1});
      q_a.push_back('{inc: 32'h0200_0000, per: 32'd2048, tol: 0, chk_per: 1'b1});
      run_a(0, 128, 1'b0, 2, 5000, "back_to_back");
   endtask

   task automatic test_noise();
      q_a.push_back('{inc: 32'h0080_0000, per: 32'd8192, tol: 0, chk_per: 1'b1});
      run_a(1, 512, 1'b0, 1, 9500, "noise");
   endtask

   task automatic test_abort();
      bit r;
      int n;
      int rx0;
      en_a = 1'b1;
      drive(0, 64, 4000, 1'b0, 1'b0, 1000, 3, 1500, r, n);
      tests_run++;
      if (!r) begin
         failed++;
         $display("FAIL abort_reach never entered DIVIDE, leds=%0d", bus_a.leds);
      end
      rx0 = rx_a;
      en_a = 1'b0;
      tick();
      tests_run++;
      if (bus_a.leds !== 3'd0 || bus_a.busy !== 1'b0 ||
          bus_a.incremento !== 32'h0080_0000 || bus_a.periodo !== 32'd8192) begin
         failed++;
         $display("FAIL abort_state leds=%0d busy=%b inc=%h per=%0d, want 0 0 00800000 8192",
                  bus_a.leds, bus_a.busy, bus_a.incremento, bus_a.periodo);
      end
      for (int i = 0; i < 60; i++) tick();
      tests_run++;
      if (rx_a !== rx0) begin
         failed++;
         $display("FAIL abort_no_valid results=%0d, want %0d", rx_a, rx0);
      end
   endtask

   task automatic test_timeout();
      bit r;
      int n;
      q_b.push_back('{inc: 32'h0400_0000, per: 32'd1024, tol: 0, chk_per: 1'b1});
      en_b = 1'b1;
      drive(0, 64, 4000, 1'b0, 1'b1, rx_b + 1, -1, 1500, r, n);
      tests_run++;
      if (!r) begin
         failed++;
         $display("FAIL timeout_first no result on 12-bit instance, got %0d", rx_b);
      end
      en_b = 1'b0;
      tick();
      tick();
      en_b = 1'b1;
      drive(3, 1, 1000, 1'b0, 1'b1, 1000, 5, 5000, r, n);
      tests_run++;
      if (!r || n < 4090 || n > 4105) begin
         failed++;
         $display("FAIL timeout_when reached=%b samples=%0d, want about 4097", r, n);
      end
      tick();
      tests_run++;
      if (bus_b.timeout !== 1'b1 || bus_b.incremento !== 32'h0400_0000 || bus_b.periodo !== 12'd1024) begin
         failed++;
         $display("FAIL timeout_flag to=%b inc=%h per=%0d, want 1 04000000 1024",
                  bus_b.timeout, bus_b.incremento, bus_b.periodo);
      end
      q_b.push_back('{inc: 32'h0400_0000, per: 32'd1024, tol: 0, chk_per: 1'b1});
      drive(0, 64, 4000, 1'b0, 1'b1, rx_b + 1, -1, 1500, r, n);
      tests_run++;
      if (!r) begin
         failed++;
         $display("FAIL timeout_recover no result after timeout, got %0d", rx_b);
      end
      en_b = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      en_a = 1'b0;
      en_b = 1'b0;
      s_valid = 1'b0;
      s_sample = '0;
      test_reset();
      test_square();
      test_valid_toggle();
      test_dds();
      test_back_to_back();
      test_noise();
      test_abort();
      test_timeout();
      tests_run++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         failed++;
         $display("FAIL sb_drain pending a=%0d b=%0d, want 0 0", q_a.size(), q_b.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end
endmodule
